// File: rtl/mem_input_queue.sv
// Memory-stage input queue: buffers execute results in a FIFO, runs load/store
// entries through the memory request/done handshake and writes back in order.
// Optional MEMQ_BYPASS_EN: ALU results arriving at an empty, idle queue write back one cycle early.
module mem_input_queue #(
   parameter int ROBsize    = 8,
   parameter int ROBsizeLog = $clog2(ROBsize + 1),
   parameter int DEPTH      = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [63:0]           dataFromExec_i,
   input  logic [9:0]            commandsFromExec_i,
   input  logic [ROBsizeLog-1:0] tagFromExec_i,
   input  logic [3:0]            flagsFromExec_i,
   input  logic                  valid_i,
   output logic                  stall_o,
   output logic                  overflow_o,
   output logic                  memReq_o,
   output logic [63:0]           memAddr_o,
   output logic                  memWrite_o,
   output logic [7:0]            memCmd_o,
   input  logic                  memDone_i,
   input  logic [63:0]           memRdata_i,
   output logic                  wbValid_o,
   output logic [63:0]           wbData_o,
   output logic [ROBsizeLog-1:0] wbTag_o,
   output logic [3:0]            wbFlags_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
   localparam logic [CW-1:0] STALL_C  = CW'(DEPTH - 1);
   localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [ROBsizeLog-1:0] TAG_ZERO = {ROBsizeLog{1'b0}};

   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

   logic [63:0]           data_q_r  [DEPTH];
   logic [9:0]            cmd_q_r   [DEPTH];
   logic [ROBsizeLog-1:0] tag_q_r   [DEPTH];
   logic [3:0]            flags_q_r [DEPTH];
   logic [PW-1:0]         rd_ptr_r;
   logic [PW-1:0]         wr_ptr_r;
   logic [CW-1:0]         count_r;
   state_t                state_r;
   state_t                state_s;

   logic [63:0]           head_data_s;
   logic [9:0]            head_cmd_s;
   logic [ROBsizeLog-1:0] head_tag_s;
   logic [3:0]            head_flags_s;
   logic                  empty_s;
   logic                  full_s;
   logic                  bypass_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  overflow_s;
   logic                  mem_load_s;
   logic                  wb_load_s;
   logic [63:0]           wb_data_s;
   logic [ROBsizeLog-1:0] wb_tag_s;
   logic [3:0]            wb_flags_s;

   logic [63:0]           mem_addr_r;
   logic                  mem_write_r;
   logic [7:0]            mem_cmd_r;
   logic                  overflow_r;
   logic                  wb_valid_r;
   logic [63:0]           wb_data_r;
   logic [ROBsizeLog-1:0] wb_tag_r;
   logic [3:0]            wb_flags_r;

   assign head_data_s  = data_q_r[rd_ptr_r];
   assign head_cmd_s   = cmd_q_r[rd_ptr_r];
   assign head_tag_s   = tag_q_r[rd_ptr_r];
   assign head_flags_s = flags_q_r[rd_ptr_r];
   assign empty_s      = (count_r == CNT_ZERO);
   assign full_s       = (count_r == FULL_C);

`ifdef MEMQ_BYPASS_EN
   assign bypass_s = valid_i && !commandsFromExec_i[9] && empty_s && (state_r == IDLE);
`else
   assign bypass_s = 1'b0;
`endif

   // A pop in the same cycle frees the slot, so a full queue can still accept
   assign push_s     = valid_i && !bypass_s && (!full_s || pop_s);
   assign overflow_s = valid_i && full_s && !pop_s;

   // FIFO storage, pointers and occupancy
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q_r[i]  <= 64'd0;
            cmd_q_r[i]   <= 10'd0;
            tag_q_r[i]   <= TAG_ZERO;
            flags_q_r[i] <= 4'd0;
         end
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
      end else begin
         if (push_s) begin
            data_q_r[wr_ptr_r]  <= dataFromExec_i;
            cmd_q_r[wr_ptr_r]   <= commandsFromExec_i;
            tag_q_r[wr_ptr_r]   <= tagFromExec_i;
            flags_q_r[wr_ptr_r] <= flagsFromExec_i;
            wr_ptr_r            <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state, pop decision and writeback source selection
   always_comb begin
      state_s    = state_r;
      pop_s      = 1'b0;
      mem_load_s = 1'b0;
      wb_load_s  = 1'b0;
      wb_data_s  = head_data_s;
      wb_tag_s   = head_tag_s;
      wb_flags_s = head_flags_s;
      case (state_r)
         IDLE: begin
            if (bypass_s) begin
               wb_load_s  = 1'b1;
               wb_data_s  = dataFromExec_i;
               wb_tag_s   = tagFromExec_i;
               wb_flags_s = flagsFromExec_i;
            end else if (empty_s) begin
               state_s = IDLE;
            end else if (head_cmd_s[9]) begin
               state_s    = BUSY;
               mem_load_s = 1'b1;
            end else begin
               pop_s     = 1'b1;
               wb_load_s = 1'b1;
            end
         end
         BUSY: begin
            if (memDone_i) begin
               state_s   = IDLE;
               pop_s     = 1'b1;
               wb_load_s = 1'b1;
               // Stores write back their address, loads the returned data
               if (head_cmd_s[8]) begin
                  wb_data_s = head_data_s;
               end else begin
                  wb_data_s = memRdata_i;
               end
            end else begin
               state_s = BUSY;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Memory request fields, sticky overflow and writeback outputs
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         mem_addr_r  <= 64'd0;
         mem_write_r <= 1'b0;
         mem_cmd_r   <= 8'd0;
         overflow_r  <= 1'b0;
         wb_valid_r  <= 1'b0;
         wb_data_r   <= 64'd0;
         wb_tag_r    <= TAG_ZERO;
         wb_flags_r  <= 4'd0;
      end else begin
         if (mem_load_s) begin
            mem_addr_r  <= head_data_s;
            mem_write_r <= head_cmd_s[8];
            mem_cmd_r   <= head_cmd_s[7:0];
         end
         if (overflow_s) begin
            overflow_r <= 1'b1;
         end
         wb_valid_r <= wb_load_s;
         if (wb_load_s) begin
            wb_data_r  <= wb_data_s;
            wb_tag_r   <= wb_tag_s;
            wb_flags_r <= wb_flags_s;
         end
      end
   end

   assign stall_o    = (count_r >= STALL_C);
   assign overflow_o = overflow_r;
   assign memReq_o   = (state_r == BUSY);
   assign memAddr_o  = mem_addr_r;
   assign memWrite_o = mem_write_r;
   assign memCmd_o   = mem_cmd_r;
   assign wbValid_o  = wb_valid_r;
   assign wbData_o   = wb_data_r;
   assign wbTag_o    = wb_tag_r;
   assign wbFlags_o  = wb_flags_r;

endmodule

// File: tb/tb_mem_input_queue.sv
// Scoreboard bench for mem_input_queue: directed timing scenarios followed by
// randomized traffic against a queue-level reference of the writeback stream.
module tb_mem_input_queue;

   localparam int ROBsize = 8;
   localparam int TW      = $clog2(ROBsize + 1);
   localparam int DEPTH   = 4;
`ifdef MEMQ_BYPASS_EN
   localparam int ALU_LAT = 1;
`else
   localparam int ALU_LAT = 2;
`endif

   logic          clk = 1'b0;
   logic          reset_i;
   logic [63:0]   dataFromExec_i;
   logic [9:0]    commandsFromExec_i;
   logic [TW-1:0] tagFromExec_i;
   logic [3:0]    flagsFromExec_i;
   logic          valid_i;
   logic          stall_o;
   logic          overflow_o;
   logic          memReq_o;
   logic [63:0]   memAddr_o;
   logic          memWrite_o;
   logic [7:0]    memCmd_o;
   logic          memDone_i;
   logic [63:0]   memRdata_i;
   logic          wbValid_o;
   logic [63:0]   wbData_o;
   logic [TW-1:0] wbTag_o;
   logic [3:0]    wbFlags_o;

   mem_input_queue #(.ROBsize(ROBsize), .DEPTH(DEPTH)) dut (
      .clk_i(clk), .reset_i(reset_i),
      .dataFromExec_i(dataFromExec_i), .commandsFromExec_i(commandsFromExec_i),
      .tagFromExec_i(tagFromExec_i), .flagsFromExec_i(flagsFromExec_i),
      .valid_i(valid_i), .stall_o(stall_o), .overflow_o(overflow_o),
      .memReq_o(memReq_o), .memAddr_o(memAddr_o), .memWrite_o(memWrite_o),
      .memCmd_o(memCmd_o), .memDone_i(memDone_i), .memRdata_i(memRdata_i),
      .wbValid_o(wbValid_o), .wbData_o(wbData_o), .wbTag_o(wbTag_o),
      .wbFlags_o(wbFlags_o)
   );

   always #5 clk = ~clk;

   typedef struct { logic [63:0] data; logic [TW-1:0] tag; logic [3:0] flags; } wb_t;
   typedef struct { string name; logic [63:0] act; logic [63:0] exp; } chk_t;
   typedef struct { logic [63:0] addr; logic write; logic [7:0] cmd; } mreq_t;

   wb_t   exp_q[$];
   chk_t  chk_q[$];
   mreq_t mem_q[$];
   int    n_cmp = 0;
   int    n_fail = 0;
   bit    auto_mem = 1'b0;
   bit    in_req = 1'b0;
   int    wait_cnt = 0;
   logic [63:0] req_addr;

   // Backing-store contents the bench's memory returns for a load address
   function automatic logic [63:0] memfn(input logic [63:0] a);
      return {a[31:0], ~a[63:32]} ^ 64'h0123_4567_89AB_CDEF;
   endfunction

   task automatic compare(input string n, input logic [63:0] a, input logic [63:0] e);
      n_cmp++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h, required 0x%0h", n, a, e);
      end
   endtask

   // Monitor: performs queued checks and scores every writeback against the reference
   initial begin
      chk_t c;
      wb_t  e;
      forever begin
         @(negedge clk);
         while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            compare(c.name, c.act, c.exp);
         end
         if (wbValid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               compare("wb_extra", {63'd0, wbValid_o}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               compare("wb_data", wbData_o, e.data);
               compare("wb_tag", 64'(wbTag_o), 64'(e.tag));
               compare("wb_flags", 64'(wbFlags_o), 64'(e.flags));
            end
         end
      end
   end

   task automatic req(input string n, input logic [63:0] a, input logic [63:0] e);
      chk_q.push_back('{name: n, act: a, exp: e});
   endtask

   task automatic push_exp(input logic [63:0] d, input logic [TW-1:0] t, input logic [3:0] f);
      exp_q.push_back('{data: d, tag: t, flags: f});
   endtask

   task automatic drive(input logic [63:0] d, input logic [9:0] c, input logic [TW-1:0] t, input logic [3:0] f);
      valid_i = 1'b1; dataFromExec_i = d; commandsFromExec_i = c;
      tagFromExec_i = t; flagsFromExec_i = f;
   endtask

   task automatic idle_in();
      valid_i = 1'b0; dataFromExec_i = 64'd0; commandsFromExec_i = 10'd0;
      tagFromExec_i = '0; flagsFromExec_i = 4'd0;
   endtask

   task automatic check_zero(input string p);
      req({p, "_stall"}, {63'd0, stall_o}, 64'd0);
      req({p, "_ovf"}, {63'd0, overflow_o}, 64'd0);
      req({p, "_req"}, {63'd0, memReq_o}, 64'd0);
      req({p, "_write"}, {63'd0, memWrite_o}, 64'd0);
      req({p, "_addr"}, memAddr_o, 64'd0);
      req({p, "_cmd"}, 64'(memCmd_o), 64'd0);
      req({p, "_wbv"}, {63'd0, wbValid_o}, 64'd0);
      req({p, "_wbd"}, wbData_o, 64'd0);
      req({p, "_wbt"}, 64'(wbTag_o), 64'd0);
      req({p, "_wbf"}, 64'(wbFlags_o), 64'd0);
   endtask

   // Memory responder: random latency, checks request fields against issue order
   task automatic respond();
      mreq_t m;
      if (memReq_o === 1'b1) begin
         if (!in_req) begin
            in_req   = 1'b1;
            req_addr = memAddr_o;
            wait_cnt = $urandom_range(0, 3);
            if (mem_q.size() == 0) begin
               req("mem_extra_req", {63'd0, memReq_o}, 64'd0);
            end else begin
               m = mem_q.pop_front();
               req("mem_addr", memAddr_o, m.addr);
               req("mem_write", {63'd0, memWrite_o}, {63'd0, m.write});
               req("mem_cmd", 64'(memCmd_o), 64'(m.cmd));
            end
         end else begin
            req("mem_addr_stable", memAddr_o, req_addr);
         end
         if (wait_cnt == 0) begin
            memDone_i  = 1'b1;
            memRdata_i = memfn(memAddr_o);
            in_req     = 1'b0;
         end else begin
            wait_cnt--;
            memDone_i  = 1'b0;
            memRdata_i = {$urandom, $urandom};
         end
      end else begin
         in_req     = 1'b0;
         memDone_i  = ($urandom_range(0, 7) == 0);
         memRdata_i = {$urandom, $urandom};
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      if (auto_mem) respond();
   endtask

   task automatic issue_random();
      logic [63:0]   d;
      logic [9:0]    c;
      logic [TW-1:0] t;
      logic [3:0]    f;
      d = {$urandom, $urandom};
      t = TW'($urandom_range(0, ROBsize));
      f = 4'($urandom);
      if ($urandom_range(0, 2) == 0) begin
         c = {1'b1, 1'($urandom), 8'($urandom)};
         mem_q.push_back('{addr: d, write: c[8], cmd: c[7:0]});
         push_exp(c[8] ? d : memfn(d), t, f);
      end else begin
         c = {1'b0, 9'($urandom)};
         push_exp(d, t, f);
      end
      drive(d, c, t, f);
   endtask

   initial begin
      reset_i = 1'b0; memDone_i = 1'b0; memRdata_i = 64'd0;
      idle_in();
      cycle();
      check_zero("rst");
      cycle();
      reset_i = 1'b1;
      cycle();

      // Single ALU entry latency
      drive(64'h1234, 10'd0, TW'(3), 4'h5); push_exp(64'h1234, TW'(3), 4'h5);
      for (int c = 1; c <= 3; c++) begin
         cycle();
         idle_in();
         req("alu_lat", {63'd0, wbValid_o}, {63'd0, (c == ALU_LAT)});
      end

      // Load with done three cycles after request rises
      drive(64'h80, {1'b1, 1'b0, 8'h21}, TW'(2), 4'h9); push_exp(64'hDEAD, TW'(2), 4'h9);
      cycle(); idle_in();
      req("ld_req_head", {63'd0, memReq_o}, 64'd0);
      for (int c = 2; c <= 5; c++) begin
         cycle();
         req("ld_req", {63'd0, memReq_o}, 64'd1);
         req("ld_addr", memAddr_o, 64'h80);
         req("ld_write", {63'd0, memWrite_o}, 64'd0);
         req("ld_cmd", 64'(memCmd_o), 64'h21);
         req("ld_nowb", {63'd0, wbValid_o}, 64'd0);
      end
      memDone_i = 1'b1; memRdata_i = 64'hDEAD;
      cycle(); memDone_i = 1'b0; memRdata_i = 64'd0;
      req("ld_wb", {63'd0, wbValid_o}, 64'd1);
      req("ld_req_drop", {63'd0, memReq_o}, 64'd0);

      // Store followed by two ALU entries: ALU writebacks wait for the store
      drive(64'h100, {1'b1, 1'b1, 8'h42}, TW'(4), 4'h1); push_exp(64'h100, TW'(4), 4'h1);
      cycle(); drive(64'hA1, 10'h0FF, TW'(5), 4'h2); push_exp(64'hA1, TW'(5), 4'h2);
      cycle(); drive(64'hB2, 10'h100, TW'(6), 4'h3); push_exp(64'hB2, TW'(6), 4'h3);
      for (int c = 3; c <= 6; c++) begin
         cycle(); idle_in();
         req("st_req", {63'd0, memReq_o}, 64'd1);
         req("st_write", {63'd0, memWrite_o}, 64'd1);
         req("st_addr", memAddr_o, 64'h100);
         req("st_hold_wb", {63'd0, wbValid_o}, 64'd0);
      end
      memDone_i = 1'b1; memRdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int c = 7; c <= 9; c++) begin
         cycle(); memDone_i = 1'b0;
         req("st_order_wb", {63'd0, wbValid_o}, 64'd1);
      end
      cycle();
      req("st_wb_end", {63'd0, wbValid_o}, 64'd0);

      // Full queue: memDone and a new entry in the same cycle
      drive(64'h200, {1'b1, 1'b0, 8'h11}, TW'(7), 4'h4); push_exp(64'hBEEF, TW'(7), 4'h4);
      for (int k = 1; k <= 3; k++) begin
         cycle();
         drive(64'h300 + 64'(k), 10'd0, TW'(7 + k), 4'(k)); push_exp(64'h300 + 64'(k), TW'(7 + k), 4'(k));
      end
      cycle();
      req("full_stall", {63'd0, stall_o}, 64'd1);
      req("full_ovf", {63'd0, overflow_o}, 64'd0);
      drive(64'h3FF, 10'd0, TW'(11), 4'hF); push_exp(64'h3FF, TW'(11), 4'hF);
      memDone_i = 1'b1; memRdata_i = 64'hBEEF;
      cycle(); idle_in(); memDone_i = 1'b0;
      req("pp_stall", {63'd0, stall_o}, 64'd1);
      req("pp_ovf", {63'd0, overflow_o}, 64'd0);
      req("pp_wb", {63'd0, wbValid_o}, 64'd1);
      for (int c = 6; c <= 9; c++) begin
         cycle();
         req("pp_drain_wb", {63'd0, wbValid_o}, 64'd1);
      end
      cycle();
      req("pp_wb_end", {63'd0, wbValid_o}, 64'd0);
      req("pp_ovf_end", {63'd0, overflow_o}, 64'd0);

      // Back-pressure: memory op stuck at head, then four more pushes
      drive(64'h300, {1'b1, 1'b0, 8'h05}, TW'(12), 4'h0);
      for (int k = 1; k <= 5; k++) begin
         cycle();
         req("bp_stall", {63'd0, stall_o}, {63'd0, (k >= 3)});
         req("bp_ovf", {63'd0, overflow_o}, {63'd0, (k == 5)});
         if (k <= 4) drive(64'h400 + 64'(k), 10'd0, TW'(k), 4'(k));
         else idle_in();
      end

      // Reset with the request outstanding, then a stale memDone
      cycle();
      req("pre_rst_req", {63'd0, memReq_o}, 64'd1);
      reset_i = 1'b0; memDone_i = 1'b1; memRdata_i = 64'h5555;
      #1;
      check_zero("midrst");
      exp_q.delete();
      cycle(); cycle();
      reset_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle();
         req("stale_wb", {63'd0, wbValid_o}, 64'd0);
         req("stale_req", {63'd0, memReq_o}, 64'd0);
      end
      memDone_i = 1'b0;

      // Randomized traffic honouring stall_o
      auto_mem = 1'b1;
      for (int n = 0; n < 600; n++) begin
         cycle();
         if (!stall_o && $urandom_range(0, 3) != 0) issue_random();
         else idle_in();
      end
      cycle(); idle_in();
      for (int t = 0; t < 300 && exp_q.size() > 0; t++) cycle();
      req("drain_left", 64'(exp_q.size()), 64'd0);
      req("rand_ovf", {63'd0, overflow_o}, 64'd0);
      auto_mem = 1'b0; memDone_i = 1'b0;
      cycle(); cycle(); cycle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
